// File: rtl/irq_request_ctrl.sv
// Interrupt front-end for the CP0 hardware lines: per-source 2-FF sync, debounce,
// rising-edge or level detection, and a software/ack-controlled pending latch.
module irq_request_ctrl #(
    parameter int unsigned N_SRC      = 8,
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned DEB_W      = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [N_SRC-1:0] irq_raw,
    input  logic [N_SRC-1:0] irq_mode,
    input  logic             ack_valid,
    input  logic [2:0]       ack_num,
    input  logic [N_SRC-1:0] sw_set,
    input  logic [N_SRC-1:0] sw_clr,
    output logic [N_SRC-1:0] hw_irq,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] stable
);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [N_SRC-1:0] sync1;
    logic [N_SRC-1:0] sync2;
    logic [N_SRC-1:0] stable_d;
    logic [N_SRC-1:0] stable_nxt;
    logic [N_SRC-1:0] pending_nxt;
    logic [N_SRC-1:0] hw_irq_nxt;
    logic [N_SRC-1:0] rise;
    logic [DEB_W-1:0] cnt     [N_SRC];
    logic [DEB_W-1:0] cnt_nxt [N_SRC];

    assign rise = stable & ~stable_d;

    // Debounce: count cycles the synced input disagrees with the accepted level.
    always_comb begin
        stable_nxt = stable;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == DEB_LAST) begin
                    stable_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // Set has priority over clear so a coincident new event is never dropped.
    always_comb begin
        pending_nxt = pending;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (!irq_mode[i]) begin
                pending_nxt[i] = 1'b0;
            end else if (rise[i] || sw_set[i]) begin
                pending_nxt[i] = 1'b1;
            end else if (sw_clr[i] || (ack_valid && (ack_num == 3'(i)))) begin
                pending_nxt[i] = 1'b0;
            end
        end
    end

    // hw_irq is registered from the next-state values so it moves with pending/stable.
    always_comb begin
        hw_irq_nxt = (irq_mode & pending_nxt) | (~irq_mode & stable_nxt);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            pending  <= '0;
            hw_irq   <= '0;
            for (int unsigned i = 0; i < N_SRC; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= irq_raw;
            sync2    <= sync1;
            stable   <= stable_nxt;
            stable_d <= stable;
            pending  <= pending_nxt;
            hw_irq   <= hw_irq_nxt;
            for (int unsigned i = 0; i < N_SRC; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_irq_request_ctrl.sv
// Scoreboard bench for irq_request_ctrl: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_irq_request_ctrl;

    logic       clk;
    logic       clr_n;
    logic [7:0] irq_raw;
    logic [7:0] irq_mode;
    logic       ack_valid;
    logic [2:0] ack_num;
    logic [7:0] sw_set;
    logic [7:0] sw_clr;
    logic [7:0] hw_irq;
    logic [7:0] pending;
    logic [7:0] stable;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        int         sel;   // 0 hw_irq, 1 pending, 2 stable
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];

    irq_request_ctrl #(.N_SRC(8), .DEB_CYCLES(16), .DEB_W(16)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .irq_raw   (irq_raw),
        .irq_mode  (irq_mode),
        .ack_valid (ack_valid),
        .ack_num   (ack_num),
        .sw_set    (sw_set),
        .sw_clr    (sw_clr),
        .hw_irq    (hw_irq),
        .pending   (pending),
        .stable    (stable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: number of rising edges since the last reset release.
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string n, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h (cyc %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic expect_at(input int c, input int sel, input logic [7:0] e, input string n);
        exp_t it;
        it.cyc = c; it.sel = sel; it.exp = e; it.name = n;
        sb.push_back(it);
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s: missed at cyc %0d, expected %02h at cyc %0d", e.name, cyc, e.exp, e.cyc);
            end else begin
                case (e.sel)
                    0:       check(e.name, hw_irq, e.exp);
                    1:       check(e.name, pending, e.exp);
                    default: check(e.name, stable, e.exp);
                endcase
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time %0t exceeded bound", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        clr_n = 1'b0; irq_raw = 8'hFF; irq_mode = 8'hFF;
        ack_valid = 1'b0; ack_num = 3'd0; sw_set = '0; sw_clr = '0;

        // Reset state and post-release debounce latency
        expect_at(0,  0, 8'h00, "rst_hw");
        expect_at(0,  1, 8'h00, "rst_pend");
        expect_at(0,  2, 8'h00, "rst_stable");
        expect_at(17, 2, 8'h00, "deb_c17");
        expect_at(18, 2, 8'hFF, "deb_c18");
        expect_at(18, 1, 8'h00, "pend_c18");
        expect_at(19, 1, 8'hFF, "pend_c19");
        expect_at(19, 0, 8'hFF, "hw_c19");
        // Glitch rejection on bit 3
        expect_at(37, 2, 8'hFF, "fall3_c37");
        expect_at(38, 2, 8'hF7, "fall3_c38");
        expect_at(41, 1, 8'hF7, "swclr3");
        expect_at(45, 2, 8'hF7, "glitch_st45");
        expect_at(55, 2, 8'hF7, "glitch_st55");
        expect_at(55, 1, 8'hF7, "glitch_pend55");
        expect_at(70, 0, 8'hF7, "glitch_hw70");
        expect_at(87, 2, 8'hF7, "hold_st87");
        expect_at(88, 2, 8'hFF, "hold_st88");
        expect_at(88, 1, 8'hF7, "hold_pend88");
        expect_at(89, 1, 8'hFF, "hold_pend89");
        expect_at(89, 0, 8'hFF, "hold_hw89");
        // Ack handling
        expect_at(91, 1, 8'h05, "pend_05");
        expect_at(93, 1, 8'h01, "ack2");
        expect_at(93, 0, 8'h01, "ack2_hw");
        expect_at(95, 1, 8'h01, "ack7_nop");
        // Set/clear collisions
        expect_at(114, 2, 8'hEF, "fall4");
        expect_at(138, 1, 8'h01, "pre_rise4");
        expect_at(139, 1, 8'h11, "rise4_vs_ack");
        expect_at(141, 1, 8'h13, "swset_vs_swclr");
        // Level mode on bit 0
        expect_at(143, 1, 8'h12, "lvl_pend");
        expect_at(143, 0, 8'h13, "lvl_hw");
        expect_at(145, 0, 8'h13, "lvl_ack0_hw");
        expect_at(147, 1, 8'h12, "lvl_swset_ign");
        expect_at(165, 0, 8'h13, "lvl_hw165");
        expect_at(166, 0, 8'h12, "lvl_hw166");
        // Back to edge mode, build A5
        expect_at(169, 1, 8'h12, "l2e_norise");
        expect_at(171, 1, 8'h00, "clr_all");
        expect_at(173, 1, 8'hA5, "set_a5");
        expect_at(173, 0, 8'hA5, "hw_a5");

        #22 clr_n = 1'b1;

        wait_cyc(20);  irq_raw = 8'hF7;
        wait_cyc(40);  sw_clr = 8'h08;
        wait_cyc(41);  sw_clr = 8'h00;
        wait_cyc(42);  irq_raw = 8'hFF;
        wait_cyc(52);  irq_raw = 8'hF7;
        wait_cyc(70);  irq_raw = 8'hFF;

        wait_cyc(90);  sw_clr = 8'hFA;
        wait_cyc(91);  sw_clr = 8'h00;
        wait_cyc(92);  ack_valid = 1'b1; ack_num = 3'd2;
        wait_cyc(93);  ack_valid = 1'b0;
        wait_cyc(94);  ack_valid = 1'b1; ack_num = 3'd7;
        wait_cyc(95);  ack_valid = 1'b0;

        wait_cyc(96);  irq_raw = 8'hEF;
        wait_cyc(120); irq_raw = 8'hFF;
        wait_cyc(138); ack_valid = 1'b1; ack_num = 3'd4;
        wait_cyc(139); ack_valid = 1'b0;
        wait_cyc(140); sw_set = 8'h02; sw_clr = 8'h02;
        wait_cyc(141); sw_set = 8'h00; sw_clr = 8'h00;

        wait_cyc(142); irq_mode = 8'hFE;
        wait_cyc(144); ack_valid = 1'b1; ack_num = 3'd0;
        wait_cyc(145); ack_valid = 1'b0;
        wait_cyc(146); sw_set = 8'h01;
        wait_cyc(147); sw_set = 8'h00;
        wait_cyc(148); irq_raw = 8'hFE;

        wait_cyc(168); irq_mode = 8'hFF;
        wait_cyc(170); sw_clr = 8'hFF;
        wait_cyc(171); sw_clr = 8'h00;
        wait_cyc(172); sw_set = 8'hA5;
        wait_cyc(173); sw_set = 8'h00;

        // Asynchronous reset between clock edges
        wait_cyc(175);
        #3 clr_n = 1'b0;
        #1;
        check("async_rst_pend", pending, 8'h00);
        check("async_rst_hw", hw_irq, 8'h00);
        check("async_rst_stable", stable, 8'h00);

        irq_raw = 8'hFF;
        expect_at(3,  1, 8'h00, "post_rst_pend");
        expect_at(3,  0, 8'h00, "post_rst_hw");
        expect_at(17, 2, 8'h00, "post_rst_st17");
        expect_at(18, 2, 8'hFF, "post_rst_st18");
        @(posedge clk);
        #2 clr_n = 1'b1;

        wait_cyc(20);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
